add_accum: RTL and testbench

Window accumulator that sits directly downstream of the 8-bit operand adder in the `test` bench. It consumes the 9-bit sum stream through a valid/ready handshake and sums `WIN` consecutive samples, or fewer when a flush closes the window early. It then presents the saturated total and the sample count on a held output register, so the pyvpi scripts can check the adder over whole windows instead of single beats.

---
 rtl/add_accum_pkg.sv | 32 +++
 rtl/add_accum_if.sv | 31 +++
 rtl/add_accum_sat.sv | 24 ++
 rtl/add_accum.sv | 122 ++++++++++++
 tb/tb_add_accum.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/add_accum_pkg.sv
// add_accum_pkg: shared types and defaults for the window accumulator.
//   state_e   : FSM state encoding (ACCUM collects beats, HOLD presents result)
//   *_W_DEF   : default widths for the incoming sum, accumulator and counter
//   sat_add   : generic saturating unsigned add, widths up to 32 bits
package add_accum_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam int unsigned IN_W_DEF  = 9;
    localparam int unsigned ACC_W_DEF = 13;
    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned WIN_DEF   = 10;

    // Returns {ovf, sum}: sum clamps to (2^w)-1 when a+b exceeds it.
    // Operands are carried at 33 bits so the carry out of a 32-bit add is kept.
    function automatic logic [32:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] s;
        logic [32:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        if (s > lim) begin
            return {1'b1, lim[31:0]};
        end
        return {1'b0, s[31:0]};
    endfunction

endpackage

// File: rtl/add_accum_if.sv
// add_accum_if: stream-in / result-out handshake bundle for add_accum.
//   in_valid/in_ready/in_sum : sample stream from the operand adder
//   flush                    : close the current window early
//   out_valid/out_ready      : result handshake
//   out_total/out_count/out_ovf : held window result
// slave modport is the accumulator's view; master is the producer/consumer side.
interface add_accum_if #(
    parameter int unsigned IN_W  = add_accum_pkg::IN_W_DEF,
    parameter int unsigned ACC_W = add_accum_pkg::ACC_W_DEF,
    parameter int unsigned CNT_W = add_accum_pkg::CNT_W_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_sum;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_total;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_sum, flush, out_ready,
        output in_ready, out_valid, out_total, out_count, out_ovf
    );

    modport master (
        output in_valid, in_sum, flush, out_ready,
        input  in_ready, out_valid, out_total, out_count, out_ovf
    );
endinterface

// File: rtl/add_accum_sat.sv
// add_accum_sat: combinational saturating adder.
//   a_i   : accumulator operand (ACC_W bits)
//   b_i   : incoming sample (IN_W bits, zero-extended)
//   sum_o : a_i + b_i clamped to all-ones
//   ovf_o : high when the unclamped sum did not fit in ACC_W bits
// ACC_W must be in IN_W..32.
module add_accum_sat
    import add_accum_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] a_i,
    input  logic [IN_W-1:0]  b_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             ovf_o
);
    logic [32:0] res;

    assign res   = sat_add(32'(a_i), 32'(b_i), ACC_W);
    // Clamped value always fits in ACC_W bits; bit 32 carries the overflow flag.
    assign sum_o = ACC_W'(res);
    assign ovf_o = res[32];
endmodule

// File: rtl/add_accum.sv
// add_accum: window accumulator for the 8-bit adder's 9-bit sum stream.
// Sums WIN accepted beats (or fewer, if flush closes the window early),
// then holds the saturated total, sample count and overflow flag until
// the consumer takes it.
//   clk     : rising-edge clock
//   clear_n : asynchronous active-low reset
//   bus     : add_accum_if.slave (sample stream in, window result out)
module add_accum
    import add_accum_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned WIN   = WIN_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        clear_n,
    add_accum_if.slave  bus
);
    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_total_q, out_total_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q, out_ovf_d;

    logic             beat;
    logic [ACC_W-1:0] sum_sat;
    logic             sum_ovf;
    logic [ACC_W-1:0] acc_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic             ovf_nx;
    logic             close;

    add_accum_sat #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_sat (
        .a_i   (acc_q),
        .b_i   (bus.in_sum),
        .sum_o (sum_sat),
        .ovf_o (sum_ovf)
    );

    // in_ready depends only on the state register.
    assign beat   = (state_q == ACCUM) && bus.in_valid;

    // Post-beat values: used both for the running window and for the result
    // load, so a beat that lands with flush is counted in the result.
    assign acc_nx = beat ? sum_sat : acc_q;
    assign cnt_nx = beat ? cnt_q + CNT_W'(1) : cnt_q;
    assign ovf_nx = ovf_q | (beat & sum_ovf);

    assign close  = (state_q == ACCUM) &&
                    ((beat && (cnt_nx == CNT_W'(WIN))) ||
                     (bus.flush && ((cnt_q != '0) || beat)));

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_total_d = out_total_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            ACCUM: begin
                acc_d = acc_nx;
                cnt_d = cnt_nx;
                ovf_d = ovf_nx;
                if (close) begin
                    out_valid_d = 1'b1;
                    out_total_d = acc_nx;
                    out_count_d = cnt_nx;
                    out_ovf_d   = ovf_nx;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_total_q <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_total_q <= out_total_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = out_valid_q;
    assign bus.out_total = out_total_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_add_accum.sv
// tb_add_accum: directed bench for add_accum.
// u_dut uses default widths (WIN=10, ACC_W=13); u_sat uses ACC_W=10, WIN=4
// to reach saturation with 9-bit samples.
module tb_add_accum;
    logic clk;
    logic clear_n;
    int   tests;
    int   fails;

    add_accum_if #(.IN_W(9), .ACC_W(13), .CNT_W(8)) bus ();
    add_accum_if #(.IN_W(9), .ACC_W(10), .CNT_W(8)) bus_s ();

    add_accum #(.IN_W(9), .WIN(10), .ACC_W(13), .CNT_W(8)) u_dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus)
    );

    add_accum #(.IN_W(9), .WIN(4), .ACC_W(10), .CNT_W(8)) u_sat (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        clear_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_sum = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
        bus_s.in_valid = 1'b0; bus_s.in_sum = '0; bus_s.flush = 1'b0; bus_s.out_ready = 1'b0;

        // Reset, with a beat presented that must not be taken
        bus.in_valid = 1'b1; bus.in_sum = 9'd7;
        tick(); tick();
        clear_n = 1'b1;
        bus.in_valid = 1'b0;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_total", 32'(bus.out_total), 0);
        chk("rst_out_count", 32'(bus.out_count), 0);
        chk("rst_out_ovf",   32'(bus.out_ovf),   0);
        chk("rst_in_ready",  32'(bus.in_ready),  1);

        // Basic window: a = 0..9, b = 0
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sum   = 9'(i);
            tick();
            if (i < 9) chk("basic_no_valid_early", 32'(bus.out_valid), 0);
        end
        bus.in_valid = 1'b0;
        chk("basic_out_valid", 32'(bus.out_valid), 1);
        chk("basic_out_total", 32'(bus.out_total), 45);
        chk("basic_out_count", 32'(bus.out_count), 10);
        chk("basic_out_ovf",   32'(bus.out_ovf),   0);
        chk("basic_in_ready_hold", 32'(bus.in_ready), 0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("basic_release_valid", 32'(bus.out_valid), 0);
        chk("basic_release_ready", 32'(bus.in_ready),  1);

        // Saturation: four beats of 511 into a 10-bit accumulator
        for (int i = 0; i < 4; i++) begin
            bus_s.in_valid = 1'b1;
            bus_s.in_sum   = 9'd511;
            tick();
        end
        bus_s.in_valid = 1'b0;
        chk("sat_out_valid", 32'(bus_s.out_valid), 1);
        chk("sat_out_total", 32'(bus_s.out_total), 1023);
        chk("sat_out_ovf",   32'(bus_s.out_ovf),   1);
        chk("sat_out_count", 32'(bus_s.out_count), 4);
        bus_s.out_ready = 1'b1;
        tick();
        bus_s.out_ready = 1'b0;

        // Flush with a same-cycle beat: 5 + 6 + 7
        bus.in_valid = 1'b1; bus.in_sum = 9'd5; tick();
        bus.in_sum = 9'd6; tick();
        chk("flush_no_valid_early", 32'(bus.out_valid), 0);
        bus.in_sum = 9'd7; bus.flush = 1'b1; tick();
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        chk("flush_out_valid", 32'(bus.out_valid), 1);
        chk("flush_out_total", 32'(bus.out_total), 18);
        chk("flush_out_count", 32'(bus.out_count), 3);
        // flush during HOLD is ignored and must not disturb the result
        bus.flush = 1'b1; tick(); bus.flush = 1'b0;
        chk("flush_hold_total", 32'(bus.out_total), 18);
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
        // flush on an empty window produces nothing
        bus.flush = 1'b1; tick(); bus.flush = 1'b0;
        tick();
        chk("flush_empty_no_valid", 32'(bus.out_valid), 0);
        chk("flush_empty_in_ready", 32'(bus.in_ready),  1);

        // Backpressure: window of 1..10, then out_ready low with in_valid high
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sum   = 9'(i + 1);
            tick();
        end
        bus.in_sum = 9'd100;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", 32'(bus.in_ready),  0);
            chk("bp_valid",    32'(bus.out_valid), 1);
            chk("bp_total",    32'(bus.out_total), 55);
            chk("bp_count",    32'(bus.out_count), 10);
            tick();
        end
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
        chk("bp_release_valid", 32'(bus.out_valid), 0);
        bus.in_sum = 9'd20;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i < 9) chk("bp_next_no_valid_early", 32'(bus.out_valid), 0);
        end
        bus.in_valid = 1'b0;
        chk("bp_next_valid", 32'(bus.out_valid), 1);
        chk("bp_next_total", 32'(bus.out_total), 200);
        chk("bp_next_count", 32'(bus.out_count), 10);
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;

        // Reset mid-window: 4 beats of 3, then clear_n pulsed between edges
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sum   = 9'd3;
            tick();
        end
        bus.in_valid = 1'b0;
        #2 clear_n = 1'b0;
        #1;
        chk("mid_rst_valid",    32'(bus.out_valid), 0);
        chk("mid_rst_total",    32'(bus.out_total), 0);
        chk("mid_rst_count",    32'(bus.out_count), 0);
        chk("mid_rst_ovf",      32'(bus.out_ovf),   0);
        chk("mid_rst_in_ready", 32'(bus.in_ready),  1);
        clear_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sum   = 9'd1;
            tick();
            if (i < 9) chk("post_rst_no_valid_early", 32'(bus.out_valid), 0);
        end
        bus.in_valid = 1'b0;
        chk("post_rst_valid", 32'(bus.out_valid), 1);
        chk("post_rst_total", 32'(bus.out_total), 10);
        chk("post_rst_count", 32'(bus.out_count), 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
